// File: rtl/hazard_controller_pkg.sv
// Shared types and helpers for the rv32i pipeline hazard controller.
package hazard_controller_pkg;

  localparam int unsigned REG_IDX_W = 5;

  // Freeze tracking: which cache sides still owe a response.
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    WAIT_BOTH = 2'b01,
    WAIT_I    = 2'b10,
    WAIT_D    = 2'b11
  } hzd_state_t;

  // ID/EX control mux select; CMUX_ZERO injects a bubble.
  typedef enum logic {
    CMUX_NORMAL = 1'b0,
    CMUX_ZERO   = 1'b1
  } controlmux_sel_t;

  // A load in EX whose (non-x0) destination is read by the instruction in ID.
  function automatic logic is_load_use(
    input logic                 ex_is_load,
    input logic [REG_IDX_W-1:0] ex_rd,
    input logic [REG_IDX_W-1:0] id_rs1,
    input logic [REG_IDX_W-1:0] id_rs2
  );
    return ex_is_load && (ex_rd != REG_IDX_W'(0)) &&
           ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: cache-miss freeze, branch flush, load-use bubble.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           IF_ID_rs1_i,
  input  logic [4:0]           IF_ID_rs2_i,
  input  logic [4:0]           ID_EX_rd_i,
  input  logic                 ID_EX_is_load_i,
  input  logic                 EX_br_taken_i,
  input  logic                 imem_read_i,
  input  logic                 imem_resp_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_resp_i,
  output logic                 pc_load_o,
  output logic                 IF_ID_load_o,
  output logic                 ID_EX_load_o,
  output logic                 EX_MEM_load_o,
  output logic                 MEM_WB_load_o,
  output logic                 IF_ID_flush_o,
  output logic                 controlmux_sel_o,
  output logic                 imem_mask_o,
  output logic                 dmem_mask_o,
  output logic [CNT_WIDTH-1:0] perf_stall_o,
  output logic [CNT_WIDTH-1:0] perf_bubble_o,
  output logic [CNT_WIDTH-1:0] perf_flush_o
);

  hzd_state_t      state_q, state_d;
  logic            imem_mask_q, imem_mask_d;
  logic            dmem_mask_q, dmem_mask_d;

  logic            i_pend;
  logic            d_pend;
  logic            frozen;
  logic            load_use;
  controlmux_sel_t sel_c;
  logic            stall_inc;
  logic            bubble_inc;
  logic            flush_inc;

  // A side is pending while requested, not yet answered, and not already recorded done.
  assign i_pend   = imem_read_i & ~imem_resp_i & ~imem_mask_q;
  assign d_pend   = dmem_req_i  & ~dmem_resp_i & ~dmem_mask_q;
  assign frozen   = i_pend | d_pend;
  assign load_use = is_load_use(ID_EX_is_load_i, ID_EX_rd_i, IF_ID_rs1_i, IF_ID_rs2_i);

  // Next freeze state; masks record the side that has already been served.
  always_comb begin
    state_d     = state_q;
    imem_mask_d = 1'b0;
    dmem_mask_d = 1'b0;
    case (state_q)
      // dcache already served, only the icache can keep us frozen
      WAIT_I:  state_d = i_pend ? WAIT_I : RUN;
      // icache already served, only the dcache can keep us frozen
      WAIT_D:  state_d = d_pend ? WAIT_D : RUN;
      default: begin
        case ({i_pend, d_pend})
          2'b11:   state_d = WAIT_BOTH;
          2'b10:   state_d = WAIT_I;
          2'b01:   state_d = WAIT_D;
          default: state_d = RUN;
        endcase
      end
    endcase
    imem_mask_d = (state_d == WAIT_D);
    dmem_mask_d = (state_d == WAIT_I);
  end

  // State and mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      imem_mask_q <= 1'b0;
      dmem_mask_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_mask_q <= imem_mask_d;
      dmem_mask_q <= dmem_mask_d;
    end
  end

  // Zero-latency hazard decision: freeze > flush > load-use > normal flow.
  always_comb begin
    pc_load_o     = 1'b1;
    IF_ID_load_o  = 1'b1;
    ID_EX_load_o  = 1'b1;
    EX_MEM_load_o = 1'b1;
    MEM_WB_load_o = 1'b1;
    IF_ID_flush_o = 1'b0;
    sel_c         = CMUX_NORMAL;
    stall_inc     = 1'b0;
    bubble_inc    = 1'b0;
    flush_inc     = 1'b0;
    if (rst) begin
      // pipeline flows freely while reset is held
    end else if (frozen) begin
      pc_load_o     = 1'b0;
      IF_ID_load_o  = 1'b0;
      ID_EX_load_o  = 1'b0;
      EX_MEM_load_o = 1'b0;
      MEM_WB_load_o = 1'b0;
      stall_inc     = 1'b1;
    end else if (EX_br_taken_i) begin
      IF_ID_flush_o = 1'b1;
      sel_c         = CMUX_ZERO;
      flush_inc     = 1'b1;
    end else if (load_use) begin
      // one bubble; the load then leaves EX and MEM/WB forwarding covers the operand
      pc_load_o     = 1'b0;
      IF_ID_load_o  = 1'b0;
      sel_c         = CMUX_ZERO;
      bubble_inc    = 1'b1;
    end
  end

  assign controlmux_sel_o = sel_c;
  assign imem_mask_o      = imem_mask_q;
  assign dmem_mask_o      = dmem_mask_q;

  // Performance counters.
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (perf_stall_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (perf_bubble_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (perf_flush_o)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (4-bit counters to reach saturation).
module tb_hazard_controller;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic [4:0]    rs1, rs2, rd;
  logic          is_load, br_taken;
  logic          imem_read, imem_resp, dmem_req, dmem_resp;
  logic          pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic          if_id_flush, cmux_sel, imem_mask, dmem_mask;
  logic [CW-1:0] perf_stall, perf_bubble, perf_flush;

  int total;
  int bad;

  hazard_controller #(.CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .IF_ID_rs1_i      (rs1),
    .IF_ID_rs2_i      (rs2),
    .ID_EX_rd_i       (rd),
    .ID_EX_is_load_i  (is_load),
    .EX_br_taken_i    (br_taken),
    .imem_read_i      (imem_read),
    .imem_resp_i      (imem_resp),
    .dmem_req_i       (dmem_req),
    .dmem_resp_i      (dmem_resp),
    .pc_load_o        (pc_load),
    .IF_ID_load_o     (if_id_load),
    .ID_EX_load_o     (id_ex_load),
    .EX_MEM_load_o    (ex_mem_load),
    .MEM_WB_load_o    (mem_wb_load),
    .IF_ID_flush_o    (if_id_flush),
    .controlmux_sel_o (cmux_sel),
    .imem_mask_o      (imem_mask),
    .dmem_mask_o      (dmem_mask),
    .perf_stall_o     (perf_stall),
    .perf_bubble_o    (perf_bubble),
    .perf_flush_o     (perf_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    is_load = 1'b0; br_taken = 1'b0;
    imem_read = 1'b0; imem_resp = 1'b0;
    dmem_req = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // All five load enables packed MSB=pc .. LSB=MEM/WB.
  function automatic logic [31:0] loads();
    return {27'd0, pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();

    // Reset with a load-use presented: outputs forced to free flow.
    #1;
    is_load = 1'b1; rd = 5'd5; rs1 = 5'd5; imem_read = 1'b1;
    #1;
    check("rst_loads", loads(), 32'h1f);
    check("rst_sel", 32'(cmux_sel), 32'd0);
    check("rst_flush", 32'(if_id_flush), 32'd0);
    tick();
    do_reset();
    #1;
    check("init_masks", {30'd0, imem_mask, dmem_mask}, 32'd0);
    check("init_cnts", {20'd0, perf_stall, perf_bubble, perf_flush}, 32'd0);
    check("init_loads", loads(), 32'h1f);

    // Load-use on rs2 = x5: one bubble.
    is_load = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
    #1;
    check("lu_loads", loads(), 32'h07);
    check("lu_sel", 32'(cmux_sel), 32'd1);
    check("lu_flush", 32'(if_id_flush), 32'd0);
    tick();
    is_load = 1'b0; rd = 5'd0;
    #1;
    check("lu_after_loads", loads(), 32'h1f);
    check("lu_after_sel", 32'(cmux_sel), 32'd0);
    check("lu_bubble_cnt", 32'(perf_bubble), 32'd1);

    // Load-use on rs1.
    is_load = 1'b1; rd = 5'd12; rs1 = 5'd12; rs2 = 5'd1;
    #1;
    check("lu_rs1_loads", loads(), 32'h07);
    tick();
    idle_inputs();
    #1;
    check("lu_rs1_bubble_cnt", 32'(perf_bubble), 32'd2);

    // Load to x0 is never a hazard.
    do_reset();
    is_load = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    check("x0_loads", loads(), 32'h1f);
    check("x0_sel", 32'(cmux_sel), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("x0_bubble_cnt", 32'(perf_bubble), 32'd0);

    // Both caches miss: icache answers in cycle 3, dcache in cycle 7.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      imem_read = 1'b1;
      dmem_req  = 1'b1;
      imem_resp = (c == 3);
      dmem_resp = (c == 7);
      br_taken  = (c == 2);
      #1;
      check($sformatf("miss_loads_c%0d", c), loads(), (c < 7) ? 32'h00 : 32'h1f);
      check($sformatf("miss_imask_c%0d", c), 32'(imem_mask), (c >= 4) ? 32'd1 : 32'd0);
      check($sformatf("miss_dmask_c%0d", c), 32'(dmem_mask), 32'd0);
      check($sformatf("miss_flush_c%0d", c), 32'(if_id_flush), 32'd0);
      tick();
    end
    idle_inputs();
    #1;
    check("miss_masks_clear", {30'd0, imem_mask, dmem_mask}, 32'd0);
    check("miss_stall_cnt", 32'(perf_stall), 32'd7);
    check("miss_flush_cnt", 32'(perf_flush), 32'd0);
    check("miss_loads_run", loads(), 32'h1f);

    // dcache-only miss lasting two cycles.
    dmem_req = 1'b1;
    #1;
    check("dmiss_loads", loads(), 32'h00);
    tick();
    #1;
    check("dmiss_imask", 32'(imem_mask), 32'd1);
    tick();
    dmem_resp = 1'b1;
    #1;
    check("dmiss_resp_loads", loads(), 32'h1f);
    tick();
    idle_inputs();
    #1;
    check("dmiss_stall_cnt", 32'(perf_stall), 32'd9);
    check("dmiss_imask_clear", 32'(imem_mask), 32'd0);

    // Taken branch alongside a load-use: flush wins.
    do_reset();
    br_taken = 1'b1; is_load = 1'b1; rd = 5'd7; rs1 = 5'd7;
    #1;
    check("br_loads", loads(), 32'h1f);
    check("br_flush", 32'(if_id_flush), 32'd1);
    check("br_sel", 32'(cmux_sel), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("br_flush_cnt", 32'(perf_flush), 32'd1);
    check("br_bubble_cnt", 32'(perf_bubble), 32'd0);

    // icache miss long enough to saturate the stall counter.
    do_reset();
    imem_read = 1'b1;
    for (int c = 0; c < 15; c++) tick();
    #1;
    check("sat_at_max", 32'(perf_stall), 32'd15);
    check("sat_dmask", 32'(dmem_mask), 32'd1);
    check("sat_imask", 32'(imem_mask), 32'd0);
    tick();
    tick();
    #1;
    check("sat_hold", 32'(perf_stall), 32'd15);

    // Reset while in WAIT_I, then a stray late response.
    rst = 1'b1;
    imem_read = 1'b0;
    #1;
    check("rst_wait_loads", loads(), 32'h1f);
    tick();
    rst = 1'b0;
    imem_resp = 1'b1;
    #1;
    check("rst_wait_masks", {30'd0, imem_mask, dmem_mask}, 32'd0);
    check("rst_wait_stall", 32'(perf_stall), 32'd0);
    check("rst_wait_loads_after", loads(), 32'h1f);
    tick();
    idle_inputs();
    #1;
    check("late_resp_masks", {30'd0, imem_mask, dmem_mask}, 32'd0);
    check("late_resp_stall", 32'(perf_stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
